ifetch_unit: RTL



---
 rtl/ifetch_unit_pkg.sv | 14 +
 rtl/ifetch_unit_if.sv | 22 ++
 rtl/ifetch_unit_fifo.sv | 45 ++++
 rtl/ifetch_unit.sv | 50 +++++
 4 files changed

// File: rtl/ifetch_unit_pkg.sv
// pygmy_defs: shared fetch-path widths, entry layout and FSM encoding for PYGMY-V32I
package pygmy_defs;
    localparam int XLEN = 32;
    localparam int ILEN = 32;
    localparam int INSTR_ALIGN = 2;
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } fetch_entry_t;
    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } fetch_state_t;
endpackage

// File: rtl/ifetch_unit_if.sv
// ifetch_unit_if: ROM port, redirect and decode handshake of the fetch stage
interface ifetch_unit_if #(parameter int DEPTH = 2);
    import pygmy_defs::*;
    logic [XLEN-1:0] rom_addr_o;
    logic [ILEN-1:0] rom_rdata_i;
    logic redirect_i;
    logic [XLEN-1:0] redirect_pc_i;
    logic instr_valid_o;
    logic [ILEN-1:0] instr_o;
    logic [XLEN-1:0] instr_pc_o;
    logic instr_ready_i;
    // prefetch occupancy, exported for observability
    logic [$clog2(DEPTH+1)-1:0] fifo_level;
    modport master (
        output rom_addr_o, instr_valid_o, instr_o, instr_pc_o, fifo_level,
        input rom_rdata_i, redirect_i, redirect_pc_i, instr_ready_i
    );
    modport slave (
        input rom_addr_o, instr_valid_o, instr_o, instr_pc_o, fifo_level,
        output rom_rdata_i, redirect_i, redirect_pc_i, instr_ready_i
    );
endinterface

// File: rtl/ifetch_unit_fifo.sv
// fetch_fifo: prefetch buffer with head read from storage registers; flush wins over push/pop
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic flush,
    input  logic push,
    input  logic pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] head,
    output logic full,
    output logic empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;
    assign full = count == CW'(DEPTH);
    assign empty = count == '0;
    assign do_pop = pop && !empty;
    // when full, a same-edge pop frees the slot the push lands in
    assign do_push = push && (!full || do_pop);
    assign head = mem[rd_ptr];
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            if (do_push) mem[wr_ptr] <= wdata;
            wr_ptr <= do_push ? wr_ptr + 1'b1 : wr_ptr;
            rd_ptr <= do_pop ? rd_ptr + 1'b1 : rd_ptr;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/ifetch_unit.sv
// ifetch_unit: PYGMY-V32I fetch stage; fetch_pc/FSM drive the ROM, fetch_fifo feeds decode
module ifetch_unit
    import pygmy_defs::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int DEPTH = 2
) (
    input logic clk_i,
    input logic rst_i,
    ifetch_unit_if.master bus
);
    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'((1 << INSTR_ALIGN) - 1);
    fetch_state_t state, state_next;
    logic [XLEN-1:0] fetch_pc;
    logic push, pop, full, empty;
    logic [$clog2(DEPTH+1)-1:0] count;
    fetch_entry_t head, wdata;
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= BOOT;
        else state <= state_next;
    end
    always_comb state_next = (state == BOOT || bus.redirect_i) ? RUN : state;
    always_comb begin
        pop = bus.instr_valid_o && bus.instr_ready_i && !bus.redirect_i;
        push = state == RUN && !bus.redirect_i && (!full || pop);
        wdata = '{pc: fetch_pc, instr: bus.rom_rdata_i};
    end
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) fetch_pc <= RESET_PC;
        else if (bus.redirect_i) fetch_pc <= bus.redirect_pc_i & ~ALIGN_MASK;
        else if (push) fetch_pc <= fetch_pc + XLEN'(4);
    end
    fetch_fifo #(.DEPTH(DEPTH), .WIDTH(XLEN + ILEN)) u_fifo (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .flush(bus.redirect_i),
        .push(push),
        .pop(pop),
        .wdata(wdata),
        .head(head),
        .full(full),
        .empty(empty),
        .count(count)
    );
    assign bus.rom_addr_o = fetch_pc;
    assign bus.instr_valid_o = !empty;
    assign bus.instr_o = head.instr;
    assign bus.instr_pc_o = head.pc;
    assign bus.fifo_level = count;
endmodule
